if_stage: RTL and testbench

Instruction-fetch stage of the 5-stage pipelined MIPS core: holds the program counter, selects the next PC, drives the instruction-memory address and owns the IF/ID pipeline register. It sits directly upstream of the hazard detection unit. It consumes that unit's `PC_ld` and `IF_ID_ld` stall controls and the ID stage's branch/jump redirect and flush, and it produces the IF/ID fields the hazard unit compares (`IF_ID_inst[25:21]` = Rs, `[20:16]` = Rt).

---
 rtl/if_stage.sv | 95 +++++++++
 tb/tb_if_stage.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: PC register, next-PC select and IF/ID register; optional counters under IF_STAGE_CNT_EN.
// Latency: a fetched word reaches IF/ID one edge after the PC points at it; a redirect takes effect on the next edge.
// Backpressure: PC_ld / IF_ID_ld low hold PC / IF/ID; a stalled IF/ID ignores IF_flush.
module if_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PC_ld,
  input  logic        IF_ID_ld,
  input  logic        IF_flush,
  input  logic [1:0]  PC_src,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  input  logic [31:0] jr_target,
  output logic [31:0] inst_mem_addr,
  input  logic [31:0] inst_mem_data,
  output logic [31:0] IF_ID_inst,
  output logic [31:0] IF_ID_pc4,
  output logic        IF_ID_valid
`ifdef IF_STAGE_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("if_stage: CNT_W must be at least 1");
  end

  logic [31:0] pc_q;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;

  assign pc_plus4      = pc_q + 32'd4;
  assign inst_mem_addr = pc_q;

  always_comb begin
    next_pc = pc_plus4;
    case (PC_src)
      2'b01:   next_pc = branch_target;
      2'b10:   next_pc = jump_target;
      2'b11:   next_pc = jr_target;
      default: next_pc = pc_plus4;
    endcase
  end

  // A redirect seen while PC_ld is low is dropped; ID re-presents it after the stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= PC_RESET;
    end else if (PC_ld) begin
      pc_q <= next_pc;
    end
  end

  // Hold outranks flush: the redirecting instruction in ID is itself stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      IF_ID_inst  <= NOP_INST;
      IF_ID_pc4   <= 32'd0;
      IF_ID_valid <= 1'b0;
    end else if (IF_ID_ld) begin
      if (IF_flush) begin
        IF_ID_inst  <= NOP_INST;
        IF_ID_pc4   <= 32'd0;
        IF_ID_valid <= 1'b0;
      end else begin
        IF_ID_inst  <= inst_mem_data;
        IF_ID_pc4   <= pc_plus4;
        IF_ID_valid <= 1'b1;
      end
    end
  end

`ifdef IF_STAGE_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!PC_ld && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (IF_flush && IF_ID_ld && (flush_cnt != {CNT_W{1'b1}})) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Randomised and directed check of if_stage against a cycle-level reference model.
module tb_if_stage;

  localparam logic [31:0] PC_RESET = 32'h0000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0000;
  localparam int          CNT_W    = 2;
  localparam int          CNT_MAX  = 3;

  logic        clk;
  logic        rst;
  logic        PC_ld;
  logic        IF_ID_ld;
  logic        IF_flush;
  logic [1:0]  PC_src;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] jr_target;
  logic [31:0] inst_mem_addr;
  logic [31:0] inst_mem_data;
  logic [31:0] IF_ID_inst;
  logic [31:0] IF_ID_pc4;
  logic        IF_ID_valid;
`ifdef IF_STAGE_CNT_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference state
  logic [31:0] m_pc;
  logic [31:0] m_inst;
  logic [31:0] m_pc4;
  logic        m_valid;
  int          m_stall;
  int          m_flush;

  if_stage #(
    .PC_RESET (PC_RESET),
    .NOP_INST (NOP_INST),
    .CNT_W    (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .PC_ld         (PC_ld),
    .IF_ID_ld      (IF_ID_ld),
    .IF_flush      (IF_flush),
    .PC_src        (PC_src),
    .branch_target (branch_target),
    .jump_target   (jump_target),
    .jr_target     (jr_target),
    .inst_mem_addr (inst_mem_addr),
    .inst_mem_data (inst_mem_data),
    .IF_ID_inst    (IF_ID_inst),
    .IF_ID_pc4     (IF_ID_pc4),
    .IF_ID_valid   (IF_ID_valid)
`ifdef IF_STAGE_CNT_EN
    ,
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: each word equals its own address.
  assign inst_mem_data = inst_mem_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("inst_mem_addr", inst_mem_addr, m_pc);
    chk("IF_ID_inst", IF_ID_inst, m_inst);
    chk("IF_ID_pc4", IF_ID_pc4, m_pc4);
    chk("IF_ID_valid", {31'd0, IF_ID_valid}, {31'd0, m_valid});
`ifdef IF_STAGE_CNT_EN
    chk("stall_cnt", {30'd0, stall_cnt}, m_stall);
    chk("flush_cnt", {30'd0, flush_cnt}, m_flush);
`endif
  endtask

  // One clock: drive inputs, advance the model by the stage's rules, compare after the edge.
  task automatic step(input bit r, input bit pl, input bit il, input bit fl,
                      input bit [1:0] src, input logic [31:0] bt,
                      input logic [31:0] jt, input logic [31:0] jrt);
    logic [31:0] old_pc;
    logic [31:0] targets [4];
    rst = r; PC_ld = pl; IF_ID_ld = il; IF_flush = fl; PC_src = src;
    branch_target = bt; jump_target = jt; jr_target = jrt;
    @(posedge clk);
    old_pc = m_pc;
    targets[0] = old_pc + 32'd4;
    targets[1] = bt;
    targets[2] = jt;
    targets[3] = jrt;
    if (r) begin
      m_pc = PC_RESET; m_inst = NOP_INST; m_pc4 = 32'd0; m_valid = 1'b0;
      m_stall = 0; m_flush = 0;
    end else begin
      if (pl) m_pc = targets[src];
      if (il && fl) begin
        m_inst = NOP_INST; m_pc4 = 32'd0; m_valid = 1'b0;
      end else if (il) begin
        m_inst = old_pc; m_pc4 = old_pc + 32'd4; m_valid = 1'b1;
      end
      if (!pl && m_stall < CNT_MAX) m_stall++;
      if (fl && il && m_flush < CNT_MAX) m_flush++;
    end
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 1, 0, 2'b00, 32'd0, 32'd0, 32'd0);
  endtask

  initial begin
    m_pc = 32'hxxxx_xxxx; m_inst = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0;
    m_stall = 0; m_flush = 0;
    rst = 1'b1; PC_ld = 1'b1; IF_ID_ld = 1'b1; IF_flush = 1'b0; PC_src = 2'b00;
    branch_target = '0; jump_target = '0; jr_target = '0;

    // Reset state, then free-running fetch 0,4,8,C
    step(1, 1, 1, 0, 2'b00, 32'd0, 32'd0, 32'd0);
    step(1, 1, 1, 0, 2'b00, 32'd0, 32'd0, 32'd0);
    chk("reset_addr_const", inst_mem_addr, 32'h0);
    chk("reset_valid_const", {31'd0, IF_ID_valid}, 32'd0);
    run(4);
    chk("seq_addr_const", inst_mem_addr, 32'h10);
    chk("seq_pc4_const", IF_ID_pc4, 32'h10);

    // Two stall cycles at 0x10, then release
    step(0, 0, 0, 0, 2'b00, 32'd0, 32'd0, 32'd0);
    step(0, 0, 0, 0, 2'b00, 32'd0, 32'd0, 32'd0);
    run(1);
    chk("stall_release_inst", IF_ID_inst, 32'h10);
    chk("stall_release_pc4", IF_ID_pc4, 32'h14);

    // Taken branch with flush: one bubble then word@0x40
    step(0, 1, 1, 1, 2'b01, 32'h40, 32'd0, 32'd0);
    chk("branch_addr", inst_mem_addr, 32'h40);
    run(1);
    chk("branch_inst", IF_ID_inst, 32'h40);

    // Jump + flush during stall is ignored, then honoured after release
    step(0, 0, 0, 1, 2'b10, 32'd0, 32'h100, 32'd0);
    step(0, 1, 1, 1, 2'b10, 32'd0, 32'h100, 32'd0);
    chk("jump_addr", inst_mem_addr, 32'h100);
    run(2);

    // PC wrap at the top of the address space
    step(0, 1, 1, 1, 2'b11, 32'd0, 32'd0, 32'hFFFF_FFFC);
    step(0, 1, 1, 0, 2'b00, 32'd0, 32'd0, 32'd0);
    chk("wrap_addr", inst_mem_addr, 32'h0);
    chk("wrap_pc4", IF_ID_pc4, 32'h0);

    // Mismatched load enables
    step(0, 1, 0, 1, 2'b01, 32'h200, 32'd0, 32'd0);
    step(0, 0, 1, 0, 2'b10, 32'd0, 32'h300, 32'd0);
    step(0, 0, 1, 1, 2'b00, 32'd0, 32'd0, 32'd0);
    step(0, 1, 0, 0, 2'b00, 32'd0, 32'd0, 32'd0);
    run(2);

    // Reset in the middle of a stall+flush request
    step(1, 0, 0, 1, 2'b11, 32'd0, 32'd0, 32'h500);
    run(2);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      bit r, pl, il, fl;
      bit [1:0] src;
      logic [31:0] bt, jt, jrt;
      r   = ($urandom_range(0, 49) == 0);
      pl  = ($urandom_range(0, 3) != 0);
      il  = ($urandom_range(0, 4) != 0) ? pl : 1'($urandom_range(0, 1));
      fl  = ($urandom_range(0, 3) == 0);
      src = fl ? 2'($urandom_range(1, 3)) : (($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b00);
      bt  = $urandom;
      jt  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : {$urandom} & 32'hFFFF_FFFC;
      jrt = $urandom;
      step(r, pl, il, fl, src, bt, jt, jrt);
    end

`ifdef IF_STAGE_CNT_EN
    // Counter saturation and clear
    step(1, 1, 1, 0, 2'b00, 32'd0, 32'd0, 32'd0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 2'b00, 32'd0, 32'd0, 32'd0);
    chk("stall_cnt_sat", {30'd0, stall_cnt}, 32'd3);
    step(1, 1, 1, 0, 2'b00, 32'd0, 32'd0, 32'd0);
    chk("stall_cnt_clr", {30'd0, stall_cnt}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
